// File: rtl/cic_readout_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cic_readout_scheduler
//  Brief    : Frames 24-bit CIC samples onto a back-pressured byte stream with
//             a one-deep pending slot and overrun reporting.
//             Optional header byte {4'hA, seq} enabled by macro HDR_BYTE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module cic_readout_scheduler #(
    parameter int DATA_W    = 24,
    parameter int BYTE_W    = 8,
    parameter int OVR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_W-1:0]    sample_in,
    input  logic                 sample_stb,
    output logic [BYTE_W-1:0]    byte_out,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic                 byte_first,
    output logic                 byte_last,
    output logic                 busy,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] ovr_count,
    input  logic                 overrun_clr
);

`ifdef HDR_BYTE_EN
    localparam int C_HDR_N = 1;
`else
    localparam int C_HDR_N = 0;
`endif
    localparam int C_NB    = DATA_W / BYTE_W + C_HDR_N;
    localparam int C_IDX_W = (C_NB > 1) ? $clog2(C_NB) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_NB - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [C_IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic [DATA_W-1:0]      pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    logic                   overrun_q, overrun_d;
    logic [OVR_CNT_W-1:0]   ovr_cnt_q, ovr_cnt_d;
`ifdef HDR_BYTE_EN
    logic [3:0]             seq_q, seq_d;
`endif

    logic                   w_accept;
    logic                   w_hs;
    logic                   w_last;
    logic                   w_drop;
    logic [C_IDX_W-1:0]     w_k;
    logic [BYTE_W-1:0]      w_data_byte;

    assign w_accept = sample_stb & enable;
    assign w_hs     = (state_q == S_SEND) & byte_ready;
    assign w_last   = (idx_q == C_LAST_IDX);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        ovr_cnt_d   = ovr_cnt_q;
        w_drop      = 1'b0;
`ifdef HDR_BYTE_EN
        seq_d       = seq_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    hold_d  = sample_in;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            default: begin
                if (w_hs && w_last) begin
`ifdef HDR_BYTE_EN
                    seq_d = seq_q + 4'd1;
`endif
                    idx_d = '0;
                    // Pending sample (if any) goes first; a coincident strobe
                    // refills the slot it just vacated, so nothing is dropped.
                    if (pend_full_q) begin
                        hold_d = pend_q;
                        if (w_accept) pend_d = sample_in;
                        else          pend_full_d = 1'b0;
                    end else if (w_accept) begin
                        hold_d = sample_in;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (w_hs) idx_d = idx_q + 1'b1;
                    if (w_accept) begin
                        if (!pend_full_q) begin
                            pend_d      = sample_in;
                            pend_full_d = 1'b1;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end
            end
        endcase

        // A clear coincident with a drop discards that drop.
        if (overrun_clr) begin
            overrun_d = 1'b0;
            ovr_cnt_d = '0;
        end else if (w_drop) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != {OVR_CNT_W{1'b1}}) ovr_cnt_d = ovr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
`ifdef HDR_BYTE_EN
            seq_q       <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
`ifdef HDR_BYTE_EN
            seq_q       <= seq_d;
`endif
        end
    end

    // Data byte index, excluding the header slot; MSB byte goes out first.
`ifdef HDR_BYTE_EN
    assign w_k = (idx_q == '0) ? '0 : idx_q - 1'b1;
`else
    assign w_k = idx_q;
`endif
    assign w_data_byte = hold_q[DATA_W-1-int'(w_k)*BYTE_W -: BYTE_W];

    always_comb begin
        byte_out = '0;
        if (state_q == S_SEND) begin
`ifdef HDR_BYTE_EN
            if (idx_q == '0) byte_out = BYTE_W'({4'hA, seq_q});
            else             byte_out = w_data_byte;
`else
            byte_out = w_data_byte;
`endif
        end
    end

    assign byte_valid = (state_q == S_SEND);
    assign byte_first = (state_q == S_SEND) & (idx_q == '0);
    assign byte_last  = (state_q == S_SEND) & w_last;
    assign busy       = (state_q != S_IDLE) | pend_full_q;
    assign overrun    = overrun_q;
    assign ovr_count  = ovr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_readout_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cic_readout_scheduler
//  Brief    : Scoreboard bench for cic_readout_scheduler (honours HDR_BYTE_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_cic_readout_scheduler;

`ifdef HDR_BYTE_EN
    localparam int C_HDR_N = 1;
`else
    localparam int C_HDR_N = 0;
`endif
    localparam int C_NB = 3 + C_HDR_N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [23:0] sample_in = '0;
    logic        sample_stb = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        byte_first;
    logic        byte_last;
    logic        busy;
    logic        overrun;
    logic [7:0]  ovr_count;
    logic        overrun_clr = 1'b0;

    typedef struct {
        logic [7:0] b;
        logic       f;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   seq_m  = 0;

    always #5 clk = ~clk;

    cic_readout_scheduler #(.DATA_W(24), .BYTE_W(8), .OVR_CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_in   (sample_in),
        .sample_stb  (sample_stb),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .byte_first  (byte_first),
        .byte_last   (byte_last),
        .busy        (busy),
        .overrun     (overrun),
        .ovr_count   (ovr_count),
        .overrun_clr (overrun_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] first_byte(input logic [23:0] d);
`ifdef HDR_BYTE_EN
        logic [3:0] s;
        s = seq_m[3:0];
        return {4'hA, s};
`else
        return d[23:16];
`endif
    endfunction

    task automatic push_frame(input logic [23:0] d);
        exp_t e;
`ifdef HDR_BYTE_EN
        logic [3:0] s;
        s = seq_m[3:0];
        e.b = {4'hA, s}; e.f = 1'b1; e.l = 1'b0;
        q.push_back(e);
        seq_m = (seq_m + 1) % 16;
`endif
        for (int k = 0; k < 3; k++) begin
            e.b = d[23-8*k -: 8];
            e.f = (k == 0) && (C_HDR_N == 0);
            e.l = (k == 2);
            q.push_back(e);
        end
    endtask

    task automatic strobe(input logic [23:0] d);
        sample_in  = d;
        sample_stb = 1'b1;
        step();
        sample_stb = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) step();
        chk("drain_left", q.size(), 0);
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", byte_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("byte_out", byte_out, e.b);
                chk("byte_first", byte_first, e.f);
                chk("byte_last", byte_last, e.l);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fb;
        // Reset state
        step();
        chk("rst_valid", byte_valid, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", ovr_count, 0);
        rst = 1'b0;
        step();

        // Single frame, latency 1 clk
        byte_ready = 1'b1;
        fb = first_byte(24'hA1B2C3);
        push_frame(24'hA1B2C3);
        strobe(24'hA1B2C3);
        chk("lat_valid", byte_valid, 1);
        chk("lat_byte", byte_out, fb);
        chk("lat_first", byte_first, 1);
        wait_drain();
        chk("t1_busy", busy, 0);
        chk("t1_valid", byte_valid, 0);

        // Back-pressure on B2
        push_frame(24'hA1B2C3);
        strobe(24'hA1B2C3);
        for (int i = 0; i < 1 + C_HDR_N; i++) step();
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_byte", byte_out, 8'hB2);
            chk("bp_valid", byte_valid, 1);
            step();
        end
        byte_ready = 1'b1;
        wait_drain();

        // Overrun
        byte_ready = 1'b0;
        push_frame(24'h111111);
        push_frame(24'h222222);
        strobe(24'h111111);
        strobe(24'h222222);
        strobe(24'h333333);
        chk("ovr_flag", overrun, 1);
        chk("ovr_cnt", ovr_count, 1);
        chk("ovr_busy", busy, 1);
        byte_ready = 1'b1;
        wait_drain();
        chk("ovr_flag_hold", overrun, 1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("clr_flag", overrun, 0);
        chk("clr_cnt", ovr_count, 0);

        // Strobe coincident with last-byte handshake, pending empty
        push_frame(24'hA1B2C3);
        strobe(24'hA1B2C3);
        for (int i = 0; i < C_NB - 1; i++) step();
        chk("co_last", byte_last, 1);
        fb = first_byte(24'hDDEEFF);
        push_frame(24'hDDEEFF);
        strobe(24'hDDEEFF);
        chk("co_valid", byte_valid, 1);
        chk("co_byte", byte_out, fb);
        wait_drain();

        // enable=0 ignores strobes
        enable = 1'b0;
        strobe(24'h123456);
        chk("en_valid", byte_valid, 0);
        chk("en_busy", busy, 0);
        chk("en_ovr", overrun, 0);
        enable = 1'b1;

        // Reset mid-frame
        byte_ready = 1'b0;
        strobe(24'hABCDEF);
        chk("pre_rst_valid", byte_valid, 1);
        rst = 1'b1;
        #1;
        seq_m = 0;
        chk("mid_rst_valid", byte_valid, 0);
        chk("mid_rst_byte", byte_out, 0);
        chk("mid_rst_first", byte_first, 0);
        chk("mid_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        byte_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", byte_valid, 0);
        end
        push_frame(24'h000001);
        strobe(24'h000001);
        wait_drain();

`ifdef HDR_BYTE_EN
        // Sequence wrap across 17 frames
        for (int i = 0; i < 17; i++) begin
            push_frame(24'h010203 + 24'(i));
            strobe(24'h010203 + 24'(i));
            wait_drain();
        end
`endif

        step();
        chk("end_busy", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
